izh_param_loader: RTL and testbench
===================================

IZH_PARAM_LOADER -- requirements
Module: izh_param_loader

Interface
REQ-001 SHALL have parameter DEF_A, default 8'd2, meaning reset value of recovery rate a.
REQ-002 SHALL have parameter DEF_B, default 8'd20, meaning reset value of sensitivity b.
REQ-003 SHALL have parameter DEF_C, default 8'hBF (-65 signed), meaning reset value of post-spike reset c.
REQ-004 SHALL have parameter DEF_D, default 8'd8, meaning reset value of post-spike increment d.
REQ-005 SHALL have the following ports, with the clock and reset listed first:
- clk  input  1  sole clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  global enable.
- input_enable  input  1  user request to run the neuron.
- load_mode  input  1  frame-valid for serial loading.
- serial_data  input  1  serial bit, MSB-first.
- param_a, param_b, param_c, param_d  output  8 each  active parameter set.
- params_ready  output  1  active set valid and not being replaced.
- load_error  output  1  last frame rejected.
- step_en  output  1  neuron datapath update enable.
- debug_state  output  3  current FSM state encoding.

Function
REQ-006 SHALL implement FSM states IDLE=3'd0, SHIFT=3'd1, CHECK=3'd2, ERROR=3'd3; debug_state SHALL equal the registered state.
REQ-007 SHALL register load_mode each cycle (load_q) and detect a start as load_mode=1 with load_q=0.
REQ-008 IDLE: on start SHALL go to SHIFT and clear the 6-bit bit counter; otherwise SHALL remain in IDLE.
REQ-009 SHIFT: each cycle with load_mode=1 SHALL shift serial_data into the LSB of a 40-bit shift register and increment the counter.
- The first bit SHALL be sampled the cycle after the start cycle.
REQ-010 SHIFT: on the cycle the 40th bit is sampled (counter=39), SHALL go to CHECK.
REQ-011 SHIFT: if load_mode=0 before 40 bits, SHALL go to ERROR and set load_error=1.
REQ-012 Frame layout SHALL be bits[39:32]=a, [31:24]=b, [23:16]=c, [15:8]=d, [7:0]=checksum, where checksum = a^b^c^d.
REQ-013 CHECK lasts one cycle and SHALL evaluate the checksum:
- Match: SHALL load the four bytes into param_a..d (visible the next cycle), clear load_error and go to IDLE.
- Mismatch: SHALL leave the params unchanged, set load_error=1 and go to ERROR.
REQ-014 ERROR: SHALL stay until load_mode=0, then go to IDLE; load_error SHALL hold until the next successful commit or reset.
REQ-015 params_ready SHALL be 0 in SHIFT and CHECK, and 1 in IDLE and ERROR (the previous set remains valid).
REQ-016 step_en SHALL be combinational: enable & input_enable & params_ready & (state==IDLE).
REQ-017 If load_mode stays high after CHECK, IDLE SHALL NOT restart until load_mode falls and rises again.
REQ-018 While enable=0, the FSM SHALL still accept frames; only step_en is gated.
REQ-019 Parameter registers SHALL change only at reset or at a CHECK-pass edge, never mid-frame.

Reset
REQ-020 While reset=1 at a clock edge, the block SHALL take the reset values:
- state=IDLE, counter=0, shift register=0, load_q=0.
- param_a..d=DEF_A..DEF_D.
- params_ready=1, load_error=0.
REQ-021 Reset asserted during SHIFT or CHECK SHALL abandon the frame and SHALL NOT commit it.

Structure
REQ-022 A shared package izh_pkg SHALL hold the state encodings, FRAME_BITS=40, PARAM_W=8 and the default parameter constants.
REQ-023 The block SHALL be a single module with no sub-module; it is instantiated between the top-level I/O and the neuron datapath, which consumes param_a..d and step_en.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then read the parameters -> a=2, b=20, c=8'hBF, d=8, params_ready=1, debug_state=0.
- Frame a=8'h03, b=8'h19, c=8'hC1, d=8'h02, checksum 8'hD9, with load_mode held high for 41 cycles -> params update on the edge after CHECK; params_ready=0 for exactly 41 cycles (40 SHIFT + 1 CHECK); load_error=0.
- Same frame with checksum 8'h00 -> params unchanged, load_error=1, debug_state=3 until load_mode falls, then 0.
- load_mode dropped after 17 bits -> ERROR, load_error=1, params unchanged.
- enable=1, input_enable=1 -> step_en=1 in IDLE; step_en=0 throughout SHIFT and CHECK; step_en=0 whenever enable=0.
- reset pulsed at bit 30 of a valid frame -> defaults restored, no commit; a full valid frame after reset commits.

Source files
------------

// File: rtl/izh_pkg.sv
`default_nettype none
// ============================================================================
// Package  : izh_pkg
// Purpose  : Shared constants for the Izhikevich neuron parameter loader:
//            FSM state encodings, frame geometry, default parameter values
//            and the frame checksum helper.
// Revision : 1.0 - initial release
// ============================================================================
package izh_pkg;

  localparam int FRAME_BITS = 40;
  localparam int PARAM_W    = 8;
  localparam int CNT_W      = 6;

  // FSM state encodings (also exported on debug_state)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_ERROR = 3'd3;

  // Index of the final frame bit; reaching it ends the SHIFT phase
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(FRAME_BITS - 1);

  // Power-on parameter set (regular-spiking neuron, c = -65)
  localparam logic [PARAM_W-1:0] C_DEF_A = 8'd2;
  localparam logic [PARAM_W-1:0] C_DEF_B = 8'd20;
  localparam logic [PARAM_W-1:0] C_DEF_C = 8'hBF;
  localparam logic [PARAM_W-1:0] C_DEF_D = 8'd8;

  // Frame is {a, b, c, d, checksum}; checksum is the XOR of the four bytes
  function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] frame);
    return (frame[39:32] ^ frame[31:24] ^ frame[23:16] ^ frame[15:8]) == frame[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/izh_param_loader.sv
`default_nettype none
// ============================================================================
// Module   : izh_param_loader
// Purpose  : Serial loader for the a/b/c/d parameters of an Izhikevich neuron.
//            Accepts 40-bit MSB-first frames framed by load_mode, validates
//            an XOR checksum and atomically swaps in the new parameter set.
//            Gates the neuron step enable while a frame is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module izh_param_loader
  import izh_pkg::*;
#(
  parameter logic [7:0] DEF_A = C_DEF_A,
  parameter logic [7:0] DEF_B = C_DEF_B,
  parameter logic [7:0] DEF_C = C_DEF_C,
  parameter logic [7:0] DEF_D = C_DEF_D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       input_enable,
  input  logic       load_mode,
  input  logic       serial_data,
  output logic [7:0] param_a,
  output logic [7:0] param_b,
  output logic [7:0] param_c,
  output logic [7:0] param_d,
  output logic       params_ready,
  output logic       load_error,
  output logic       step_en,
  output logic [2:0] debug_state
);

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic                  r_load_q;
  logic                  w_start;
  logic [CNT_W-1:0]      r_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [7:0]            r_a, r_b, r_c, r_d;
  logic                  r_err;
  logic                  w_sum_ok;

  // A frame starts only on a rising edge of load_mode, so a level held high
  // after a commit cannot retrigger a load.
  assign w_start  = load_mode & ~r_load_q;
  assign w_sum_ok = checksum_ok(r_shift);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (!load_mode)                w_state_nxt = ST_ERROR;
        else if (r_cnt == C_LAST_BIT)  w_state_nxt = ST_CHECK;
      end
      ST_CHECK: w_state_nxt = w_sum_ok ? ST_IDLE : ST_ERROR;
      ST_ERROR: if (!load_mode) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs; the previous parameter set stays usable in IDLE and ERROR
  always_comb begin
    params_ready = (r_state == ST_IDLE) || (r_state == ST_ERROR);
    step_en      = enable & input_enable & params_ready & (r_state == ST_IDLE);
    debug_state  = r_state;
  end

  // Frame datapath: edge detector, bit counter, shifter, commit and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_q <= 1'b0;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_a      <= DEF_A;
      r_b      <= DEF_B;
      r_c      <= DEF_C;
      r_d      <= DEF_D;
      r_err    <= 1'b0;
    end else begin
      r_load_q <= load_mode;
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) r_cnt <= '0;
        end
        ST_SHIFT: begin
          if (load_mode) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], serial_data};
            r_cnt   <= r_cnt + 1'b1;
          end else begin
            r_err   <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_sum_ok) begin
            r_a   <= r_shift[39:32];
            r_b   <= r_shift[31:24];
            r_c   <= r_shift[23:16];
            r_d   <= r_shift[15:8];
            r_err <= 1'b0;
          end else begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign param_a    = r_a;
  assign param_b    = r_b;
  assign param_c    = r_c;
  assign param_d    = r_d;
  assign load_error = r_err;

endmodule
`default_nettype wire

// File: tb/tb_izh_param_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_izh_param_loader
// Purpose  : Directed self-checking bench for izh_param_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_izh_param_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       input_enable = 1'b0;
  logic       load_mode = 1'b0;
  logic       serial_data = 1'b0;
  logic [7:0] param_a, param_b, param_c, param_d;
  logic       params_ready, load_error, step_en;
  logic [2:0] debug_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Statistics gathered while a frame is shifted in
  int ready_low_cnt;
  int step_hi_cnt;
  int param_change_cnt;

  localparam logic [39:0] FRAME_GOOD = 40'h03_19_C1_02_D9;
  localparam logic [39:0] FRAME_BAD  = 40'h03_19_C1_02_00;
  localparam logic [39:0] FRAME_ALT  = 40'h05_0A_F0_11_EE;

  izh_param_loader dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .input_enable (input_enable),
    .load_mode    (load_mode),
    .serial_data  (serial_data),
    .param_a      (param_a),
    .param_b      (param_b),
    .param_c      (param_c),
    .param_d      (param_d),
    .params_ready (params_ready),
    .load_error   (load_error),
    .step_en      (step_en),
    .debug_state  (debug_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise load_mode (start cycle) then shift nbits bits MSB-first,
  // tallying params_ready-low cycles, step_en-high cycles and param changes.
  task automatic shift_bits(input logic [39:0] f, input int nbits);
    logic [31:0] p0;
    p0 = {param_a, param_b, param_c, param_d};
    ready_low_cnt = 0;
    step_hi_cnt = 0;
    param_change_cnt = 0;
    load_mode = 1'b1;
    tick();
    if (!params_ready) ready_low_cnt++;
    if (step_en) step_hi_cnt++;
    for (int i = 0; i < nbits; i++) begin
      serial_data = f[39-i];
      tick();
      if (!params_ready) ready_low_cnt++;
      if (step_en) step_hi_cnt++;
      if ({param_a, param_b, param_c, param_d} !== p0) param_change_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if ({param_a, param_b, param_c, param_d} !== 32'h02_14_BF_08) begin
      n_fail++;
      $display("FAIL reset_params: got %h expected %h", {param_a, param_b, param_c, param_d}, 32'h02_14_BF_08);
    end
    n_tests++;
    if ({params_ready, load_error, debug_state} !== 5'b10_000) begin
      n_fail++;
      $display("FAIL reset_status: got rdy/err/st=%b expected 10000", {params_ready, load_error, debug_state});
    end
  endtask

  task automatic test_step_en();
    enable = 1'b1; input_enable = 1'b1;
    #1;
    n_tests++;
    if (step_en !== 1'b1) begin n_fail++; $display("FAIL step_en_idle: got %b expected 1", step_en); end
    enable = 1'b0;
    #1;
    n_tests++;
    if (step_en !== 1'b0) begin n_fail++; $display("FAIL step_en_disabled: got %b expected 0", step_en); end
    enable = 1'b1; input_enable = 1'b0;
    #1;
    n_tests++;
    if (step_en !== 1'b0) begin n_fail++; $display("FAIL step_en_no_input: got %b expected 0", step_en); end
    input_enable = 1'b1;
  endtask

  task automatic test_good_frame();
    shift_bits(FRAME_GOOD, 40);
    n_tests++;
    if (debug_state !== 3'd2) begin n_fail++; $display("FAIL good_in_check: got %0d expected 2", debug_state); end
    n_tests++;
    if (param_change_cnt != 0) begin n_fail++; $display("FAIL good_no_early_commit: got %0d changes expected 0", param_change_cnt); end
    n_tests++;
    if (step_hi_cnt != 0) begin n_fail++; $display("FAIL good_step_gated: got %0d high cycles expected 0", step_hi_cnt); end
    load_mode = 1'b0;
    tick();
    n_tests++;
    if (ready_low_cnt != 41) begin n_fail++; $display("FAIL good_ready_low: got %0d cycles expected 41", ready_low_cnt); end
    n_tests++;
    if ({param_a, param_b, param_c, param_d} !== 32'h03_19_C1_02) begin
      n_fail++;
      $display("FAIL good_commit: got %h expected %h", {param_a, param_b, param_c, param_d}, 32'h03_19_C1_02);
    end
    n_tests++;
    if ({params_ready, load_error, debug_state, step_en} !== 6'b10_000_1) begin
      n_fail++;
      $display("FAIL good_status: got rdy/err/st/step=%b expected 100001", {params_ready, load_error, debug_state, step_en});
    end
    tick();
  endtask

  task automatic test_bad_checksum();
    shift_bits(FRAME_BAD, 40);
    tick();   // CHECK -> ERROR, load_mode still high
    n_tests++;
    if ({debug_state, load_error, params_ready} !== 5'b011_1_1) begin
      n_fail++;
      $display("FAIL bad_error_state: got st/err/rdy=%b expected 01111", {debug_state, load_error, params_ready});
    end
    tick(); tick();
    n_tests++;
    if (debug_state !== 3'd3) begin n_fail++; $display("FAIL bad_hold_error: got %0d expected 3", debug_state); end
    n_tests++;
    if ({param_a, param_b, param_c, param_d} !== 32'h03_19_C1_02) begin
      n_fail++;
      $display("FAIL bad_params_kept: got %h expected %h", {param_a, param_b, param_c, param_d}, 32'h03_19_C1_02);
    end
    load_mode = 1'b0;
    tick();
    n_tests++;
    if ({debug_state, load_error} !== 4'b000_1) begin
      n_fail++;
      $display("FAIL bad_exit: got st/err=%b expected 0001", {debug_state, load_error});
    end
    tick();
  endtask

  task automatic test_short_frame();
    shift_bits(FRAME_ALT, 17);
    load_mode = 1'b0;
    tick();
    n_tests++;
    if ({debug_state, load_error} !== 4'b011_1) begin
      n_fail++;
      $display("FAIL short_error: got st/err=%b expected 0111", {debug_state, load_error});
    end
    tick();
    n_tests++;
    if ({debug_state, load_error} !== 4'b000_1) begin
      n_fail++;
      $display("FAIL short_to_idle: got st/err=%b expected 0001", {debug_state, load_error});
    end
    n_tests++;
    if ({param_a, param_b, param_c, param_d} !== 32'h03_19_C1_02) begin
      n_fail++;
      $display("FAIL short_params_kept: got %h expected %h", {param_a, param_b, param_c, param_d}, 32'h03_19_C1_02);
    end
  endtask

  task automatic test_reset_mid_frame();
    shift_bits(FRAME_GOOD, 30);
    reset = 1'b1;
    load_mode = 1'b0;
    tick();
    reset = 1'b0;
    n_tests++;
    if ({param_a, param_b, param_c, param_d} !== 32'h02_14_BF_08) begin
      n_fail++;
      $display("FAIL midreset_defaults: got %h expected %h", {param_a, param_b, param_c, param_d}, 32'h02_14_BF_08);
    end
    n_tests++;
    if ({debug_state, load_error, params_ready} !== 5'b000_0_1) begin
      n_fail++;
      $display("FAIL midreset_status: got st/err/rdy=%b expected 00001", {debug_state, load_error, params_ready});
    end
    tick(); tick();
    n_tests++;
    if ({param_a, param_b, param_c, param_d} !== 32'h02_14_BF_08) begin
      n_fail++;
      $display("FAIL midreset_no_commit: got %h expected %h", {param_a, param_b, param_c, param_d}, 32'h02_14_BF_08);
    end
  endtask

  // Valid frame after the mid-frame reset, with load_mode left high after
  // the commit: the loader must stay in IDLE until a fresh rising edge.
  task automatic test_back_to_back();
    shift_bits(FRAME_ALT, 40);
    tick();   // CHECK -> IDLE, load_mode still high
    n_tests++;
    if ({param_a, param_b, param_c, param_d} !== 32'h05_0A_F0_11) begin
      n_fail++;
      $display("FAIL alt_commit: got %h expected %h", {param_a, param_b, param_c, param_d}, 32'h05_0A_F0_11);
    end
    tick(); tick(); tick();
    n_tests++;
    if ({debug_state, params_ready, load_error} !== 5'b000_1_0) begin
      n_fail++;
      $display("FAIL held_no_restart: got st/rdy/err=%b expected 00010", {debug_state, params_ready, load_error});
    end
    load_mode = 1'b0;
    tick();
    enable = 1'b0;
    shift_bits(FRAME_GOOD, 40);
    load_mode = 1'b0;
    tick();
    n_tests++;
    if ({param_a, param_b, param_c, param_d, step_en} !== {32'h03_19_C1_02, 1'b0}) begin
      n_fail++;
      $display("FAIL disabled_commit: got %h/%b expected 0319c102/0", {param_a, param_b, param_c, param_d}, step_en);
    end
  endtask

  initial begin
    test_reset();
    test_step_en();
    test_good_frame();
    test_bad_checksum();
    test_short_frame();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
